up_down_counter: RTL and testbench

//  - Synchronous binary up/down counter with a single direction-select input.
//  - M=1 counts up, M=0 counts down, one step per rising clock edge.
//  - Default width is 4 bits; the counter wraps modulo 2**WIDTH.
//  - Generic leaf block for sequencers, address generators and timers.

---
 rtl/up_down_counter.sv | 70 +++++++
 tb/tb_up_down_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter.sv
// Up/down binary counter with registered output and a 2-flop reset-release synchronizer.
// Optional macro UP_DOWN_COUNTER_SATURATE_EN clamps at 0 and 2**WIDTH-1 instead of wrapping.
module up_down_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             M,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [1:0]       sync_reg;
  logic             step_en;
  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;

  // Assertion clears both stages at once; release shifts a 1 through the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], 1'b1};
    end
  end

  // Stepping starts on the edge that loads the second stage (2nd edge after
  // release) and stays on while the second stage holds the settled value.
  assign step_en = sync_reg[0] | sync_reg[1];

  always_comb begin
    cnt_next = cnt_reg;
    if (step_en) begin
      if (M) begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
        if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CNT_ONE;
        end
`else
        cnt_next = cnt_reg + CNT_ONE;
`endif
      end else begin
`ifdef UP_DOWN_COUNTER_SATURATE_EN
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end
`else
        cnt_next = cnt_reg - CNT_ONE;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= RESET_VAL;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

  // An unknown direction out of reset has no defined hardware behaviour.
  m_known_a: assert property (@(posedge clk) disable iff (!rst) !$isunknown(M));

endmodule

// File: tb/tb_up_down_counter.sv
// Testbench for up_down_counter: spec-derived vector table, hand-written reset
// and direction sequences, then randomized traffic against an arithmetic model.
module tb_up_down_counter;

  typedef struct packed {
    logic       m;
    logic [3:0] exp;
  } vec_t;

`ifdef UP_DOWN_COUNTER_SATURATE_EN
  localparam int NVEC = 40;
  vec_t vecs [NVEC] = '{
    '{1'b1, 4'd0},  '{1'b1, 4'd1},  '{1'b1, 4'd2},  '{1'b1, 4'd3},  '{1'b1, 4'd4},
    '{1'b1, 4'd5},  '{1'b1, 4'd6},  '{1'b1, 4'd7},  '{1'b1, 4'd8},  '{1'b1, 4'd9},
    '{1'b1, 4'd10}, '{1'b1, 4'd11}, '{1'b1, 4'd12}, '{1'b1, 4'd13}, '{1'b1, 4'd14},
    '{1'b1, 4'd15}, '{1'b1, 4'd15}, '{1'b1, 4'd15}, '{1'b1, 4'd15}, '{1'b1, 4'd15},
    '{1'b0, 4'd14}, '{1'b0, 4'd13}, '{1'b0, 4'd12}, '{1'b0, 4'd11}, '{1'b0, 4'd10},
    '{1'b0, 4'd9},  '{1'b0, 4'd8},  '{1'b0, 4'd7},  '{1'b0, 4'd6},  '{1'b0, 4'd5},
    '{1'b0, 4'd4},  '{1'b0, 4'd3},  '{1'b0, 4'd2},  '{1'b0, 4'd1},  '{1'b0, 4'd0},
    '{1'b0, 4'd0},  '{1'b0, 4'd0},  '{1'b0, 4'd0},  '{1'b0, 4'd0},  '{1'b0, 4'd0}
  };
  localparam int WRAP8_EXP = 255;
`else
  localparam int NVEC = 36;
  vec_t vecs [NVEC] = '{
    '{1'b1, 4'd0},  '{1'b1, 4'd1},  '{1'b1, 4'd2},  '{1'b1, 4'd3},  '{1'b1, 4'd4},
    '{1'b1, 4'd5},  '{1'b1, 4'd6},  '{1'b1, 4'd7},  '{1'b1, 4'd8},  '{1'b1, 4'd9},
    '{1'b1, 4'd10}, '{1'b1, 4'd11}, '{1'b1, 4'd12}, '{1'b1, 4'd13}, '{1'b1, 4'd14},
    '{1'b1, 4'd15}, '{1'b1, 4'd0},  '{1'b1, 4'd1},  '{1'b1, 4'd2},  '{1'b1, 4'd3},
    '{1'b0, 4'd2},  '{1'b0, 4'd1},  '{1'b0, 4'd0},  '{1'b0, 4'd15}, '{1'b0, 4'd14},
    '{1'b1, 4'd15}, '{1'b1, 4'd0},  '{1'b1, 4'd1},  '{1'b1, 4'd2},  '{1'b1, 4'd3},
    '{1'b1, 4'd4},  '{1'b1, 4'd5},  '{1'b1, 4'd6},  '{1'b1, 4'd7},
    '{1'b0, 4'd6},  '{1'b1, 4'd7}
  };
  localparam int WRAP8_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic [1:0] rst_v;
  logic [1:0] m_v;
  logic [3:0] cnt4;
  logic [7:0] cnt8;

  int n_tests = 0;
  int n_fail  = 0;
  int mcnt [2];
  int since [2];
  int modv [2] = '{16, 256};
  int rv   [2] = '{0, 254};

  always #5 clk = ~clk;

  up_down_counter #(.WIDTH(4), .RESET_VAL(4'd0)) u4 (
    .clk(clk), .rst(rst_v[0]), .M(m_v[0]), .cnt(cnt4)
  );

  up_down_counter #(.WIDTH(8), .RESET_VAL(8'hFE)) u8 (
    .clk(clk), .rst(rst_v[1]), .M(m_v[1]), .cnt(cnt8)
  );

  // Reference step: plain modular or clamped arithmetic on integers.
  function automatic int step(int c, logic up, int mod);
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    if (up) return (c == mod - 1) ? c : c + 1;
    return (c == 0) ? 0 : c - 1;
`else
    if (up) return (c + 1) % mod;
    return (c + mod - 1) % mod;
`endif
  endfunction

  function automatic int actual(int d);
    return (d == 0) ? int'(cnt4) : int'(cnt8);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: cnt=%0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("[TB] ok   %s: cnt=%0d (t=%0t)", name, act, $time);
    end
  endtask

  // One rising edge; the model sees the same rst/M the DUTs sample.
  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst_v[d]) begin
        since[d]++;
        if (since[d] >= 2) mcnt[d] = step(mcnt[d], m_v[d], modv[d]);
      end
    end
    #1;
  endtask

  // Assert reset between edges and confirm it lands with no clock.
  task automatic assert_rst(input int d);
    #2;
    rst_v[d] = 1'b0;
    #1;
    mcnt[d]  = rv[d];
    since[d] = 0;
    check(d == 0 ? "async_rst4" : "async_rst8", actual(d), rv[d]);
  endtask

  initial begin
    rst_v = 2'b11;
    m_v   = 2'b00;
    for (int d = 0; d < 2; d++) begin
      mcnt[d]  = rv[d];
      since[d] = 0;
    end

    // Power-on reset: applied before the first clock edge.
    #2;
    rst_v = 2'b00;
    #1;
    check("por_rst4", int'(cnt4), 0);
    check("por_rst8", int'(cnt8), 254);
    repeat (3) begin
      m_v = 2'b11;
      tick();
      check("hold_rst4", int'(cnt4), 0);
      check("hold_rst8", int'(cnt8), 254);
    end

    // Table: release with M=1, wrap, count down, direction changes.
    rst_v[0] = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      m_v[0] = vecs[i].m;
      tick();
      check($sformatf("vec%0d", i), int'(cnt4), int'(vecs[i].exp));
    end

    // Climb to 9, then assert reset mid-count at a non-edge time.
    m_v[0] = 1'b1;
    for (int k = 0; k < 40 && mcnt[0] != 9; k++) begin
      tick();
      check("climb", int'(cnt4), mcnt[0]);
    end
    check("at_nine", int'(cnt4), 9);
    assert_rst(0);
    repeat (3) begin
      tick();
      check("mid_hold", int'(cnt4), 0);
    end

    // Release: first edge holds, second edge counts, then immediate reversal.
    rst_v[0] = 1'b1;
    m_v[0]   = 1'b1;
    tick();
    check("rel_edge1", int'(cnt4), 0);
    tick();
    check("rel_edge2", int'(cnt4), 1);
    m_v[0] = 1'b0;
    tick();
    check("rev_down", int'(cnt4), 0);
    tick();
    check("rev_under", int'(cnt4), mcnt[0]);

    // WIDTH=8, RESET_VAL=FE counting up across the top.
    rst_v[1] = 1'b1;
    m_v[1]   = 1'b1;
    tick();
    check("w8_edge1", int'(cnt8), 254);
    tick();
    check("w8_edge2", int'(cnt8), 255);
    tick();
    check("w8_edge3", int'(cnt8), WRAP8_EXP);

    // Randomized direction and reset traffic on both instances.
    for (int i = 0; i < 200; i++) begin
      m_v = 2'($urandom);
      for (int d = 0; d < 2; d++) begin
        if (!rst_v[d] && $urandom_range(0, 2) == 0) rst_v[d] = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) assert_rst(int'($urandom_range(0, 1)));
      tick();
      check("rnd4", int'(cnt4), mcnt[0]);
      check("rnd8", int'(cnt8), mcnt[1]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
